// File: rtl/tcam_pipe.sv
// Pipelined ternary CAM: one search per cycle, two-stage compare/encode pipeline
// with valid/ready backpressure, per-entry write/invalidate, flush and occupancy count.
module tcam_pipe #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int TAG_WIDTH = 4,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WIDTH-1:0]     wr_key,
    input  logic [WIDTH-1:0]     wr_mask,
    input  logic                 wr_vld,
    input  logic                 srch_valid,
    output logic                 srch_ready,
    input  logic [WIDTH-1:0]     srch_key,
    input  logic [TAG_WIDTH-1:0] srch_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic                 rsp_multi,
    output logic [IDX_W-1:0]     rsp_idx,
    output logic [DEPTH-1:0]     rsp_line,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [CNT_W-1:0]     num_valid
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

    logic [WIDTH-1:0]     key_r  [DEPTH];
    logic [WIDTH-1:0]     mask_r [DEPTH];
    logic [DEPTH-1:0]     vld_r;
    logic [CNT_W-1:0]     num_valid_r;
    logic [CNT_W-1:0]     num_valid_nxt_s;

    logic                 s1_valid_r;
    logic [DEPTH-1:0]     s1_line_r;
    logic [TAG_WIDTH-1:0] s1_tag_r;

    logic                 rsp_valid_r;
    logic                 rsp_hit_r;
    logic                 rsp_multi_r;
    logic [IDX_W-1:0]     rsp_idx_r;
    logic [DEPTH-1:0]     rsp_line_r;
    logic [TAG_WIDTH-1:0] rsp_tag_r;

    logic                 wr_legal_s;
    logic                 s2_free_s;
    logic                 srch_ready_s;
    logic [DEPTH-1:0]     match_s;
    logic [IDX_W-1:0]     enc_idx_s;
    logic                 enc_multi_s;

    // Write legality and pipeline handshake; S1 may only move when S2 is empty or draining.
    always_comb begin
        wr_legal_s   = wr_en && ({1'b0, wr_idx} < DEPTH_C);
        s2_free_s    = !rsp_valid_r || rsp_ready;
        srch_ready_s = !s1_valid_r || s2_free_s;
    end

    // Ternary compare against the table as it stands before this edge's write/flush.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = vld_r[i] && (((key_r[i] ^ srch_key) & mask_r[i]) == '0);
        end
    end

    // Lowest-index priority encode and two-or-more detection on the S1 match line.
    always_comb begin
        enc_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s1_line_r[i]) begin
                enc_idx_s = IDX_W'(i);
            end else begin
                enc_idx_s = enc_idx_s;
            end
        end
        // Clearing the lowest set bit leaves something only if a second bit was set.
        enc_multi_s = (s1_line_r & (s1_line_r - DEPTH'(1'b1))) != '0;
    end

    // Occupancy tracks only real valid-bit transitions; flush wins over any write.
    always_comb begin
        num_valid_nxt_s = num_valid_r;
        if (flush) begin
            num_valid_nxt_s = '0;
        end else if (wr_legal_s && wr_vld && !vld_r[wr_idx]) begin
            num_valid_nxt_s = num_valid_r + CNT_W'(1'b1);
        end else if (wr_legal_s && !wr_vld && vld_r[wr_idx]) begin
            num_valid_nxt_s = num_valid_r - CNT_W'(1'b1);
        end else begin
            num_valid_nxt_s = num_valid_r;
        end
    end

    // Valid bits and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r       <= '0;
            num_valid_r <= '0;
        end else begin
            num_valid_r <= num_valid_nxt_s;
            if (flush) begin
                vld_r <= '0;
            end else if (wr_legal_s) begin
                vld_r[wr_idx] <= wr_vld;
            end else begin
                vld_r <= vld_r;
            end
        end
    end

    // Key/mask storage; contents are only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_legal_s) begin
            key_r[wr_idx]  <= wr_key;
            mask_r[wr_idx] <= wr_mask;
        end
    end

    // Stage S1: registered match line and tag of the accepted search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_line_r  <= '0;
            s1_tag_r   <= '0;
        end else if (srch_ready_s) begin
            s1_valid_r <= srch_valid;
            if (srch_valid) begin
                s1_line_r <= match_s;
                s1_tag_r  <= srch_tag;
            end
        end
    end

    // Stage S2: response registers, held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_multi_r <= 1'b0;
            rsp_idx_r   <= '0;
            rsp_line_r  <= '0;
            rsp_tag_r   <= '0;
        end else if (s2_free_s) begin
            rsp_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                rsp_hit_r   <= |s1_line_r;
                rsp_multi_r <= enc_multi_s;
                rsp_idx_r   <= enc_idx_s;
                rsp_line_r  <= s1_line_r;
                rsp_tag_r   <= s1_tag_r;
            end
        end
    end

    assign srch_ready = srch_ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_hit    = rsp_hit_r;
    assign rsp_multi  = rsp_multi_r;
    assign rsp_idx    = rsp_idx_r;
    assign rsp_line   = rsp_line_r;
    assign rsp_tag    = rsp_tag_r;
    assign num_valid  = num_valid_r;

endmodule
